// File: rtl/trig_fire_ctrl_if.sv
// Bundle of trigger inputs and fire/status outputs for trig_fire_ctrl.
// The master modport drives the trigger inputs; the slave modport belongs to the controller.
interface trig_fire_if #(
  parameter int NCH = 16
);
  logic [NCH-1:0] tin_active;
  logic [NCH-1:0] coinc_mask;
  logic [31:0]    randnum;
  logic [31:0]    prescale;
  logic           dorolling;
  logic [4:0]     roll_bit;
  logic           sw_trig;
  logic           readout_busy;
  logic           ext_trig_out;
  logic [1:0]     trig_src;
  logic [31:0]    fire_count;
  logic [31:0]    reject_count;
  logic [1:0]     state_dbg;

  modport master (
    output tin_active, coinc_mask, randnum, prescale, dorolling, roll_bit,
           sw_trig, readout_busy,
    input  ext_trig_out, trig_src, fire_count, reject_count, state_dbg
  );

  modport slave (
    input  tin_active, coinc_mask, randnum, prescale, dorolling, roll_bit,
           sw_trig, readout_busy,
    output ext_trig_out, trig_src, fire_count, reject_count, state_dbg
  );
endinterface

// File: rtl/trig_fire_ctrl.sv
// Trigger fire controller: arbitrates coincidence, software and rolling triggers,
// issues a fixed-width external pulse, then enforces deadtime and readout-busy hold.
module trig_fire_ctrl #(
  parameter int NCH        = 16,
  parameter int FIRE_TICKS = 4,
  parameter int DEAD_TICKS = 20
) (
  input  logic         clk_adc,
  input  logic         nrst,
  trig_fire_if.slave   bus
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_FIRE    = 2'd1;
  localparam logic [1:0]  S_DEAD    = 2'd2;
  localparam logic [1:0]  S_HOLD    = 2'd3;
  localparam logic [1:0]  SRC_COINC = 2'd1;
  localparam logic [1:0]  SRC_SW    = 2'd2;
  localparam logic [1:0]  SRC_ROLL  = 2'd3;
  localparam logic [31:0] FIRE_LAST = 32'(FIRE_TICKS - 1);
  localparam logic [31:0] DEAD_LAST = 32'(DEAD_TICKS - 1);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] tick_q, tick_d;
  logic [1:0]  src_q, src_d;
  logic [31:0] fire_cnt_q, fire_cnt_d;
  logic [31:0] rej_cnt_q, rej_cnt_d;
  logic [31:0] roll_q, roll_d;
  logic        sw_pend_q, sw_pend_d;
  logic        roll_pend_q, roll_pend_d;
  logic        ext_q, ext_d;
  logic        coinc_s, pass_s, roll_hit_s, fire_s, sw_fire_s;

  assign coinc_s    = (bus.coinc_mask != {NCH{1'b0}}) &&
                      ((bus.tin_active & bus.coinc_mask) == bus.coinc_mask);
  assign pass_s     = (bus.randnum <= bus.prescale);
  assign roll_hit_s = roll_q[bus.roll_bit];

  // A tick counter times both the pulse and the deadtime; a rejected coincidence skips FIRE.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    src_d      = src_q;
    fire_cnt_d = fire_cnt_q;
    rej_cnt_d  = rej_cnt_q;
    fire_s     = 1'b0;
    sw_fire_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coinc_s) begin
          if (pass_s && !bus.readout_busy) begin
            fire_s = 1'b1;
            src_d  = SRC_COINC;
          end else begin
            state_d   = S_DEAD;
            tick_d    = DEAD_LAST;
            rej_cnt_d = sat_inc(rej_cnt_q);
          end
        end else if (sw_pend_q && !bus.readout_busy) begin
          fire_s    = 1'b1;
          sw_fire_s = 1'b1;
          src_d     = SRC_SW;
        end else if (roll_pend_q && !bus.readout_busy) begin
          fire_s = 1'b1;
          src_d  = SRC_ROLL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FIRE: begin
        if (tick_q == 32'd0) begin
          state_d = S_DEAD;
          tick_d  = DEAD_LAST;
        end else begin
          tick_d = tick_q - 32'd1;
        end
      end
      S_DEAD: begin
        if (tick_q == 32'd0) begin
          state_d = bus.readout_busy ? S_HOLD : S_IDLE;
        end else begin
          tick_d = tick_q - 32'd1;
        end
      end
      S_HOLD: begin
        if (!bus.readout_busy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = 32'd0;
      end
    endcase
    if (fire_s) begin
      state_d    = S_FIRE;
      tick_d     = FIRE_LAST;
      fire_cnt_d = sat_inc(fire_cnt_q);
    end else begin
      fire_cnt_d = fire_cnt_q;
    end
  end

  // Pending requests and the free-running rolling period counter.
  always_comb begin
    sw_pend_d = bus.sw_trig | (sw_pend_q & ~sw_fire_s);
    if (fire_s) begin
      roll_d      = 32'd0;
      roll_pend_d = 1'b0;
    end else if (roll_hit_s) begin
      roll_d      = 32'd0;
      roll_pend_d = roll_pend_q | bus.dorolling;
    end else begin
      roll_d      = roll_q + 32'd1;
      roll_pend_d = roll_pend_q;
    end
    if (!bus.dorolling) begin
      roll_pend_d = 1'b0;
    end else begin
      roll_pend_d = roll_pend_d;
    end
    ext_d = (state_d == S_FIRE);
  end

  // State and output registers; reset abandons any pulse in flight.
  always_ff @(posedge clk_adc) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      tick_q      <= 32'd0;
      src_q       <= 2'd0;
      fire_cnt_q  <= 32'd0;
      rej_cnt_q   <= 32'd0;
      roll_q      <= 32'd0;
      sw_pend_q   <= 1'b0;
      roll_pend_q <= 1'b0;
      ext_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      src_q       <= src_d;
      fire_cnt_q  <= fire_cnt_d;
      rej_cnt_q   <= rej_cnt_d;
      roll_q      <= roll_d;
      sw_pend_q   <= sw_pend_d;
      roll_pend_q <= roll_pend_d;
      ext_q       <= ext_d;
    end
  end

  assign bus.ext_trig_out = ext_q;
  assign bus.trig_src     = src_q;
  assign bus.fire_count   = fire_cnt_q;
  assign bus.reject_count = rej_cnt_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_trig_fire_ctrl.sv
// Bench for trig_fire_ctrl: directed scenarios with constant expectations plus a
// randomized run against a time-budget reference model.
module tb_trig_fire_ctrl;
  localparam int NCH = 16;
  localparam int F   = 4;
  localparam int D   = 20;

  logic clk_adc = 1'b0;
  logic nrst    = 1'b0;

  trig_fire_if #(.NCH(NCH)) bus ();

  trig_fire_ctrl #(.NCH(NCH), .FIRE_TICKS(F), .DEAD_TICKS(D)) dut (
    .clk_adc (clk_adc),
    .nrst    (nrst),
    .bus     (bus)
  );

  always #5 clk_adc = ~clk_adc;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a single budget of blocked cycles after each fire/reject
  int          m_blocked;
  bit          m_hold, m_swp, m_rp;
  logic [31:0] m_roll, m_fc, m_rc;
  logic [1:0]  m_src;

  task automatic model_reset();
    m_blocked = 0;
    m_hold = 1'b0; m_swp = 1'b0; m_rp = 1'b0;
    m_roll = 32'd0; m_fc = 32'd0; m_rc = 32'd0; m_src = 2'd0;
  endtask

  task automatic model_step();
    bit coinc, pass, busy, idle, fired, swfire;
    if (!nrst) begin
      model_reset();
      return;
    end
    coinc = (bus.coinc_mask != 16'd0) &&
            ((bus.tin_active & bus.coinc_mask) == bus.coinc_mask);
    pass  = (bus.randnum <= bus.prescale);
    busy  = bus.readout_busy;
    idle  = (m_blocked == 0) && !m_hold;
    fired = 1'b0;
    swfire = 1'b0;
    if (idle) begin
      if (coinc) begin
        if (pass && !busy) begin fired = 1'b1; m_src = 2'd1; end
        else begin
          m_blocked = D;
          if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 32'd1;
        end
      end else if (m_swp && !busy) begin
        fired = 1'b1; swfire = 1'b1; m_src = 2'd2;
      end else if (m_rp && !busy) begin
        fired = 1'b1; m_src = 2'd3;
      end
    end else if (m_blocked > 0) begin
      if (m_blocked == 1 && busy) m_hold = 1'b1;
      m_blocked = m_blocked - 1;
    end else if (!busy) begin
      m_hold = 1'b0;
    end
    if (fired) begin
      m_blocked = F + D;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
    end
    m_swp = bus.sw_trig || (m_swp && !swfire);
    if (fired) begin
      m_roll = 32'd0; m_rp = 1'b0;
    end else if (m_roll[bus.roll_bit]) begin
      m_roll = 32'd0; m_rp = m_rp || bus.dorolling;
    end else begin
      m_roll = m_roll + 32'd1;
    end
    if (!bus.dorolling) m_rp = 1'b0;
  endtask

  function automatic logic [68:0] model_out();
    logic [1:0] st;
    logic       e;
    e = (m_blocked > D);
    if (m_blocked > D)      st = 2'd1;
    else if (m_blocked > 0) st = 2'd2;
    else if (m_hold)        st = 2'd3;
    else                    st = 2'd0;
    return {e, m_src, st, m_fc, m_rc};
  endfunction

  task automatic tick();
    @(posedge clk_adc);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    bus.tin_active = 16'd0; bus.coinc_mask = 16'd0;
    bus.randnum = 32'd0; bus.prescale = 32'd0;
    bus.dorolling = 1'b0; bus.roll_bit = 5'd0;
    bus.sw_trig = 1'b0; bus.readout_busy = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({bus.ext_trig_out, bus.trig_src, bus.state_dbg, bus.fire_count, bus.reject_count} !== 69'd0)
      $display("FAIL reset_state: got ext=%b src=%0d st=%0d fc=%0d rc=%0d want all 0",
               bus.ext_trig_out, bus.trig_src, bus.state_dbg, bus.fire_count, bus.reject_count);
    else n_pass++;
  endtask

  task automatic test_coinc_fire();
    int high = 0;
    int first = -1;
    do_reset();
    bus.coinc_mask = 16'h0003; bus.tin_active = 16'h0003;
    bus.prescale = 32'hFFFF_FFFF; bus.randnum = $urandom;
    tick();
    bus.tin_active = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      if (bus.ext_trig_out) begin
        high++;
        if (first < 0) first = i;
      end
      tick();
    end
    n_total++;
    if (first !== 0) $display("FAIL coinc_first_high: got %0d want 0", first); else n_pass++;
    n_total++;
    if (high !== F) $display("FAIL coinc_pulse_len: got %0d want %0d", high, F); else n_pass++;
    n_total++;
    if (bus.trig_src !== 2'd1) $display("FAIL coinc_src: got %0d want 1", bus.trig_src); else n_pass++;
    n_total++;
    if (bus.fire_count !== 32'd1) $display("FAIL coinc_fire_count: got %0d want 1", bus.fire_count); else n_pass++;
  endtask

  task automatic test_reject();
    int k = 0;
    do_reset();
    bus.coinc_mask = 16'h0003; bus.tin_active = 16'h0003;
    bus.randnum = 32'd10; bus.prescale = 32'd5;
    tick();
    n_total++;
    if (bus.reject_count !== 32'd1 || bus.ext_trig_out !== 1'b0 || bus.state_dbg !== 2'd2)
      $display("FAIL reject_state: got rc=%0d ext=%b st=%0d want rc=1 ext=0 st=2",
               bus.reject_count, bus.ext_trig_out, bus.state_dbg);
    else n_pass++;
    bus.prescale = 32'hFFFF_FFFF;
    while (!bus.ext_trig_out && k < 60) begin
      tick();
      k++;
    end
    n_total++;
    if (k !== D + 1) $display("FAIL reject_retry_delay: got %0d want %0d", k, D + 1); else n_pass++;
    n_total++;
    if (bus.fire_count !== 32'd1) $display("FAIL reject_fire_count: got %0d want 1", bus.fire_count); else n_pass++;
  endtask

  task automatic test_periodic();
    int rises = 0;
    int bad = 0;
    int last = -1;
    logic prev = 1'b0;
    do_reset();
    bus.coinc_mask = 16'h0003; bus.tin_active = 16'h0003; bus.prescale = 32'hFFFF_FFFF;
    for (int c = 0; c < 250; c++) begin
      tick();
      if (bus.ext_trig_out && !prev) begin
        rises++;
        if (last >= 0 && (c - last) != F + D + 1) bad++;
        last = c;
      end
      prev = bus.ext_trig_out;
    end
    n_total++;
    if (rises !== 10) $display("FAIL periodic_rises: got %0d want 10", rises); else n_pass++;
    n_total++;
    if (bad !== 0) $display("FAIL periodic_spacing: got %0d bad gaps want 0", bad); else n_pass++;
  endtask

  task automatic test_rolling();
    int n = 0;
    int rises = 0;
    logic prev;
    do_reset();
    bus.dorolling = 1'b1; bus.roll_bit = 5'd4;
    while (!bus.ext_trig_out && n < 100) begin
      tick();
      n++;
    end
    n_total++;
    if (n !== 18) $display("FAIL roll_first_rise: got %0d want 18", n); else n_pass++;
    n_total++;
    if (bus.trig_src !== 2'd3) $display("FAIL roll_src: got %0d want 3", bus.trig_src); else n_pass++;
    n = 0;
    prev = 1'b1;
    while (!(bus.ext_trig_out && !prev) && n < 100) begin
      prev = bus.ext_trig_out;
      tick();
      n++;
    end
    n_total++;
    if (n !== F + D + 1) $display("FAIL roll_second_gap: got %0d want %0d", n, F + D + 1); else n_pass++;
    bus.dorolling = 1'b0;
    prev = bus.ext_trig_out;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.ext_trig_out && !prev) rises++;
      prev = bus.ext_trig_out;
    end
    n_total++;
    if (rises !== 0 || bus.fire_count !== 32'd2)
      $display("FAIL roll_disabled: got rises=%0d fc=%0d want rises=0 fc=2", rises, bus.fire_count);
    else n_pass++;
  endtask

  task automatic test_sw_trig();
    int highs = 0;
    int k = 0;
    logic prev;
    do_reset();
    bus.readout_busy = 1'b1; bus.sw_trig = 1'b1;
    tick();
    bus.sw_trig = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      highs += int'(bus.ext_trig_out);
    end
    n_total++;
    if (highs !== 0) $display("FAIL sw_busy_blocked: got %0d high cycles want 0", highs); else n_pass++;
    bus.readout_busy = 1'b0;
    tick();
    n_total++;
    if (bus.ext_trig_out !== 1'b1 || bus.trig_src !== 2'd2)
      $display("FAIL sw_fire: got ext=%b src=%0d want ext=1 src=2", bus.ext_trig_out, bus.trig_src);
    else n_pass++;
    repeat (30) tick();
    bus.coinc_mask = 16'h0003; bus.tin_active = 16'h0003;
    bus.prescale = 32'hFFFF_FFFF; bus.sw_trig = 1'b1;
    tick();
    bus.tin_active = 16'h0000; bus.sw_trig = 1'b0;
    n_total++;
    if (bus.ext_trig_out !== 1'b1 || bus.trig_src !== 2'd1)
      $display("FAIL sw_coinc_first: got ext=%b src=%0d want ext=1 src=1", bus.ext_trig_out, bus.trig_src);
    else n_pass++;
    prev = 1'b1;
    while (!(bus.ext_trig_out && !prev) && k < 80) begin
      prev = bus.ext_trig_out;
      tick();
      k++;
    end
    n_total++;
    if (k !== F + D + 1 || bus.trig_src !== 2'd2)
      $display("FAIL sw_after_coinc: got gap=%0d src=%0d want gap=%0d src=2", k, bus.trig_src, F + D + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fire();
    do_reset();
    bus.coinc_mask = 16'h0003; bus.tin_active = 16'h0003; bus.prescale = 32'hFFFF_FFFF;
    tick();
    bus.tin_active = 16'h0000;
    tick();
    nrst = 1'b0;
    tick();
    n_total++;
    if ({bus.ext_trig_out, bus.trig_src, bus.state_dbg, bus.fire_count, bus.reject_count} !== 69'd0)
      $display("FAIL reset_mid_fire: got ext=%b src=%0d st=%0d fc=%0d rc=%0d want all 0",
               bus.ext_trig_out, bus.trig_src, bus.state_dbg, bus.fire_count, bus.reject_count);
    else n_pass++;
    nrst = 1'b1;
  endtask

  task automatic test_random();
    logic [68:0] got, want;
    logic [NCH-1:0] mask;
    int errs = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       mask = 16'h0000;
        1:       mask = 16'h0003;
        2:       mask = 16'h00F0;
        default: mask = NCH'($urandom);
      endcase
      bus.coinc_mask = mask;
      bus.tin_active = ($urandom_range(0, 2) == 0) ? mask : NCH'($urandom);
      bus.randnum    = $urandom;
      case ($urandom_range(0, 2))
        0:       bus.prescale = 32'hFFFF_FFFF;
        1:       bus.prescale = 32'd0;
        default: bus.prescale = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) bus.readout_busy = ~bus.readout_busy;
      bus.sw_trig = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) begin
        bus.dorolling = ~bus.dorolling;
        bus.roll_bit  = 5'($urandom_range(2, 6));
      end
      nrst = ($urandom_range(0, 299) != 0);
      tick();
      got  = {bus.ext_trig_out, bus.trig_src, bus.state_dbg, bus.fire_count, bus.reject_count};
      want = model_out();
      n_total++;
      if (got !== want) begin
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got ext=%b src=%0d st=%0d fc=%0d rc=%0d want ext=%b src=%0d st=%0d fc=%0d rc=%0d",
                   c, got[68], got[67:66], got[65:64], got[63:32], got[31:0],
                   want[68], want[67:66], want[65:64], want[63:32], want[31:0]);
        errs++;
      end else n_pass++;
    end
    nrst = 1'b1;
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_coinc_fire();
    test_reject();
    test_periodic();
    test_rolling();
    test_sw_trig();
    test_reset_mid_fire();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
